// File: rtl/mem_access_master.sv
// Load/store master: turns one CPU byte/halfword/word request at a time into a
// single word-aligned bus transfer with lane enables, data steering and an optional stall timeout.
module mem_access_master #(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byte_en,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  // The counter only has to reach MAX_WAIT-1; the transfer is abandoned on the next stalled edge.
  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
  localparam bit TIMEOUT_EN = (MAX_WAIT > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    lane_q, lane_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   address_q, address_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic [3:0]    byte_en_q, byte_en_d;
  logic [31:0]   writedata_q, writedata_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic          resp_err_q, resp_err_d;

  logic          req_is_load, req_byte, req_half, req_word, req_misaligned;
  logic [3:0]    req_be;
  logic [31:0]   req_lane_mask, req_wd;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_result;

  always_comb begin
    req_is_load    = (req_op <= OP_LW);
    req_byte       = (req_op == OP_LB) || (req_op == OP_LBU) || (req_op == OP_SB);
    req_half       = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
    req_word       = (req_op == OP_LW) || (req_op == OP_SW);
    req_misaligned = (req_half && req_addr[0]) || (req_word && (req_addr[1:0] != 2'b00));

    req_be = 4'b1111;
    if (req_byte) begin
      req_be = 4'b0001 << req_addr[1:0];
    end else if (req_half) begin
      req_be = req_addr[1] ? 4'b1100 : 4'b0011;
    end

    req_lane_mask = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
    if (req_byte) begin
      req_wd = {4{req_wdata[7:0]}} & req_lane_mask;
    end else if (req_half) begin
      req_wd = {2{req_wdata[15:0]}} & req_lane_mask;
    end else begin
      req_wd = req_wdata;
    end
  end

  // Lane extraction uses the latched op/lane, so it only depends on readdata during BUS.
  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = readdata[7:0];
      2'd1:    rd_byte = readdata[15:8];
      2'd2:    rd_byte = readdata[23:16];
      default: rd_byte = readdata[31:24];
    endcase
    rd_half = lane_q[1] ? readdata[31:16] : readdata[15:0];

    case (op_q)
      OP_LB:   load_result = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_result = {24'h0, rd_byte};
      OP_LH:   load_result = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_result = {16'h0, rd_half};
      OP_LW:   load_result = readdata;
      default: load_result = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lane_d      = lane_q;
    wait_cnt_d  = wait_cnt_q;
    address_d   = address_q;
    read_d      = read_q;
    write_d     = write_q;
    byte_en_d   = byte_en_q;
    writedata_d = writedata_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          lane_d = req_addr[1:0];
          if (req_misaligned) begin
            resp_err_d  = 1'b1;
            resp_data_d = 32'h0;
            state_d     = RESP;
          end else begin
            address_d   = {req_addr[31:2], 2'b00};
            read_d      = req_is_load;
            write_d     = !req_is_load;
            byte_en_d   = req_be;
            writedata_d = req_is_load ? 32'h0 : req_wd;
            wait_cnt_d  = '0;
            state_d     = BUS;
          end
        end
      end

      BUS: begin
        if (!waitrequest) begin
          read_d      = 1'b0;
          write_d     = 1'b0;
          byte_en_d   = 4'b0000;
          resp_err_d  = 1'b0;
          resp_data_d = load_result;
          state_d     = RESP;
        end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
          read_d      = 1'b0;
          write_d     = 1'b0;
          byte_en_d   = 4'b0000;
          resp_err_d  = 1'b1;
          resp_data_d = 32'h0;
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        read_d    = 1'b0;
        write_d   = 1'b0;
        byte_en_d = 4'b0000;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= 3'b000;
      lane_q      <= 2'b00;
      wait_cnt_q  <= '0;
      address_q   <= 32'h0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      byte_en_q   <= 4'b0000;
      writedata_q <= 32'h0;
      resp_data_q <= 32'h0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      wait_cnt_q  <= wait_cnt_d;
      address_q   <= address_d;
      read_q      <= read_d;
      write_q     <= write_d;
      byte_en_q   <= byte_en_d;
      writedata_q <= writedata_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign byte_en    = byte_en_q;
  assign writedata  = writedata_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master (MAX_WAIT=4): load extension, store steering,
// wait states, misalignment, timeout and asynchronous reset during a stalled transfer.
module tb_mem_access_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byte_en;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  int errors = 0;
  int checks = 0;
  int strobeCycles;

  mem_access_master #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .address(address), .read(read), .write(write), .byte_en(byte_en),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request while the DUT is idle, waits for the accepting edge, then scrambles req_*.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rd, input logic wr);
    req_valid   = 1'b1;
    req_op      = op;
    req_addr    = addr;
    req_wdata   = wdata;
    readdata    = rd;
    waitrequest = wr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 3'b010;
    req_addr  = 32'hFFFF_FFF1;
    req_wdata = 32'hFFFF_FFFF;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'b000; req_addr = 32'h0;
    req_wdata = 32'h0; readdata = 32'h0; waitrequest = 1'b0;

    #3;
    checkOutput("rst_read",      {31'h0, read},       32'h0);
    checkOutput("rst_write",     {31'h0, write},      32'h0);
    checkOutput("rst_byte_en",   {28'h0, byte_en},    32'h0);
    checkOutput("rst_address",   address,             32'h0);
    checkOutput("rst_writedata", writedata,           32'h0);
    checkOutput("rst_resp_valid",{31'h0, resp_valid}, 32'h0);
    checkOutput("rst_resp_err",  {31'h0, resp_err},   32'h0);
    checkOutput("rst_resp_data", resp_data,           32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);

    // LBU 0x1003, no wait
    applyStimulus(3'b001, 32'h0000_1003, 32'h0, 32'h80AA_55CC, 1'b0);
    checkOutput("lbu_read",      {31'h0, read},       32'h1);
    checkOutput("lbu_write",     {31'h0, write},      32'h0);
    checkOutput("lbu_address",   address,             32'h0000_1000);
    checkOutput("lbu_byte_en",   {28'h0, byte_en},    32'h8);
    checkOutput("lbu_req_ready", {31'h0, req_ready},  32'h0);
    checkOutput("lbu_no_resp",   {31'h0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    checkOutput("lbu_resp_valid",{31'h0, resp_valid}, 32'h1);
    checkOutput("lbu_resp_data", resp_data,           32'h0000_0080);
    checkOutput("lbu_resp_err",  {31'h0, resp_err},   32'h0);
    checkOutput("lbu_read_drop", {31'h0, read},       32'h0);
    readdata = 32'h1234_5678;
    @(posedge clk); #1;
    checkOutput("lbu_resp_pulse",{31'h0, resp_valid}, 32'h0);
    checkOutput("lbu_data_hold", resp_data,           32'h0000_0080);
    checkOutput("lbu_ready_back",{31'h0, req_ready},  32'h1);

    // LH 0x2002 with 3 wait cycles
    applyStimulus(3'b010, 32'h0000_2002, 32'h0, 32'h8001_FFFF, 1'b1);
    strobeCycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (read === 1'b1) strobeCycles++;
      checkOutput("lh_address_hold", address,          32'h0000_2000);
      checkOutput("lh_byte_en_hold", {28'h0, byte_en}, 32'hC);
      waitrequest = (i == 3) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("lh_read_cycles", strobeCycles,          32'd4);
    checkOutput("lh_read_drop",   {31'h0, read},         32'h0);
    checkOutput("lh_resp_valid",  {31'h0, resp_valid},   32'h1);
    checkOutput("lh_resp_data",   resp_data,             32'hFFFF_8001);
    checkOutput("lh_resp_err",    {31'h0, resp_err},     32'h0);
    @(posedge clk); #1;

    // SB 0x0005
    applyStimulus(3'b101, 32'h0000_0005, 32'h1234_56AB, 32'hFFFF_FFFF, 1'b0);
    checkOutput("sb_write",     {31'h0, write},    32'h1);
    checkOutput("sb_read",      {31'h0, read},     32'h0);
    checkOutput("sb_address",   address,           32'h0000_0004);
    checkOutput("sb_byte_en",   {28'h0, byte_en},  32'h2);
    checkOutput("sb_writedata", writedata,         32'h0000_AB00);
    @(posedge clk); #1;
    checkOutput("sb_resp_valid",{31'h0, resp_valid}, 32'h1);
    checkOutput("sb_resp_data", resp_data,           32'h0);
    checkOutput("sb_write_drop",{31'h0, write},      32'h0);
    @(posedge clk); #1;

    // SH 0x0002 lands in the upper lanes
    applyStimulus(3'b110, 32'h0000_0002, 32'hABCD_1234, 32'h0, 1'b0);
    checkOutput("sh_byte_en",   {28'h0, byte_en},  32'hC);
    checkOutput("sh_writedata", writedata,         32'h1234_0000);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // LB 0x3001 sign-extends lane 1
    applyStimulus(3'b000, 32'h0000_3001, 32'h0, 32'h0000_F200, 1'b0);
    checkOutput("lb_byte_en",   {28'h0, byte_en},  32'h2);
    @(posedge clk); #1;
    checkOutput("lb_resp_data", resp_data,         32'hFFFF_FFF2);
    @(posedge clk); #1;

    // LW 0x0006 misaligned: response one cycle after acceptance, no strobe
    applyStimulus(3'b100, 32'h0000_0006, 32'h0, 32'hDEAD_BEEF, 1'b0);
    checkOutput("lw_mis_read",      {31'h0, read},       32'h0);
    checkOutput("lw_mis_write",     {31'h0, write},      32'h0);
    checkOutput("lw_mis_byte_en",   {28'h0, byte_en},    32'h0);
    checkOutput("lw_mis_resp_valid",{31'h0, resp_valid}, 32'h1);
    checkOutput("lw_mis_resp_err",  {31'h0, resp_err},   32'h1);
    checkOutput("lw_mis_resp_data", resp_data,           32'h0);
    @(posedge clk); #1;
    checkOutput("lw_mis_read_after",{31'h0, read},       32'h0);
    checkOutput("lw_mis_err_hold",  {31'h0, resp_err},   32'h1);

    // LHU 0x0003 misaligned halfword
    applyStimulus(3'b011, 32'h0000_0003, 32'h0, 32'h0, 1'b0);
    checkOutput("lhu_mis_read",     {31'h0, read},     32'h0);
    checkOutput("lhu_mis_resp_err", {31'h0, resp_err}, 32'h1);
    @(posedge clk); #1;

    // LW 0x0010 aligned pass-through; also leaves non-zero resp_data before the timeout
    applyStimulus(3'b100, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    @(posedge clk); #1;
    checkOutput("lw_resp_data", resp_data,         32'hDEAD_BEEF);
    checkOutput("lw_resp_err",  {31'h0, resp_err}, 32'h0);
    @(posedge clk); #1;

    // SW with waitrequest stuck high: timeout after 4 BUS cycles
    applyStimulus(3'b111, 32'h0000_0100, 32'h0000_0055, 32'h0, 1'b1);
    checkOutput("tmo_writedata", writedata, 32'h0000_0055);
    strobeCycles = 0;
    for (int i = 0; i < 6 && resp_valid !== 1'b1; i++) begin
      if (write === 1'b1) strobeCycles++;
      @(posedge clk); #1;
    end
    checkOutput("tmo_write_cycles", strobeCycles,         32'd4);
    checkOutput("tmo_write_drop",   {31'h0, write},       32'h0);
    checkOutput("tmo_resp_valid",   {31'h0, resp_valid},  32'h1);
    checkOutput("tmo_resp_err",     {31'h0, resp_err},    32'h1);
    checkOutput("tmo_resp_data",    resp_data,            32'h0);
    @(posedge clk); #1;

    // SW stalled, then reset pulsed mid-BUS
    applyStimulus(3'b111, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 1'b1);
    checkOutput("rstbus_write", {31'h0, write}, 32'h1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstbus_write_async",  {31'h0, write},      32'h0);
    checkOutput("rstbus_byte_en",      {28'h0, byte_en},    32'h0);
    checkOutput("rstbus_address",      address,             32'h0);
    checkOutput("rstbus_writedata",    writedata,           32'h0);
    checkOutput("rstbus_resp_valid",   {31'h0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    waitrequest = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstbus_req_ready",    {31'h0, req_ready},  32'h1);
    checkOutput("rstbus_no_resp",      {31'h0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    checkOutput("rstbus_no_resp_late", {31'h0, resp_valid}, 32'h0);
    checkOutput("rstbus_no_write",     {31'h0, write},      32'h0);

    // Recovery: LHU 0x0000
    applyStimulus(3'b011, 32'h0000_0000, 32'h0, 32'h8000_FFFF, 1'b0);
    checkOutput("lhu_byte_en", {28'h0, byte_en}, 32'h3);
    @(posedge clk); #1;
    checkOutput("lhu_resp_data", resp_data, 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
